// File: rtl/srec_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : srec_load_arbiter
// Purpose  : Funnels S-record parser byte writes through a small FIFO onto a
//            single 32-bit byte-enabled memory write port. The CPU shares the
//            port and is held in reset while a load is in progress. It is
//            released once the stream has been idle for IDLE_TIMEOUT cycles.
//            Parser errors and FIFO overflow are sticky until reset_n.
// Ports    : clock, reset_n (async, active-low)
//            load_*   : parser byte-write stream and error level
//            cpu_*    : CPU write request / grant, CPU reset output
//            mem_*    : registered valid/ready memory write port
//            loading, error : status
// Options  : `define SREC_LOAD_ADDR_LIMIT_EN rejects load addresses outside
//            [LOAD_BASE, LOAD_BASE+LOAD_SIZE) and forces the error state.
// Revision : 1.0 - initial release
// ============================================================================
module srec_load_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned IDLE_TIMEOUT = 5000,
  parameter logic [31:0] LOAD_BASE    = 32'h0000_0000,
  parameter logic [31:0] LOAD_SIZE    = 32'h0001_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_error,
  input  logic [31:0] load_address,
  input  logic [7:0]  load_byte,
  input  logic        load_write,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic        cpu_gnt,
  output logic        cpu_reset_n,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  output logic        loading,
  output logic        error
);

  localparam int unsigned c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned c_cnt_w = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_idle_max = c_cnt_w'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_LOAD  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic               r_cpu_reset_n;
  logic               r_loading;
  logic               r_error;
  logic [c_cnt_w-1:0] r_idle_cnt;
  logic [c_cnt_w-1:0] w_idle_cnt_nxt;

  // FIFO entry layout: {byte address[31:0], data byte[7:0]}
  logic [39:0]        r_fifo [FIFO_DEPTH];
  logic [c_ptr_w:0]   r_wr_ptr;
  logic [c_ptr_w:0]   r_rd_ptr;
  logic [39:0]        w_head;
  logic               w_empty;
  logic               w_full;

  logic               r_mem_valid;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [3:0]         r_mem_be;
  logic               r_owner_ld;

  logic               w_xfer;
  logic               w_pop;
  logic               w_addr_ok;
  logic               w_addr_err;
  logic               w_push_req;
  logic               w_push;
  logic               w_overflow;
  logic               w_idle_now;
  logic               w_ld_issue;
  logic               w_cpu_gnt;

`ifdef SREC_LOAD_ADDR_LIMIT_EN
  // 33-bit upper bound so a window ending at 2^32 does not wrap to zero.
  logic [32:0]        w_lim_hi;
  logic               w_unused_cfg;
  assign w_lim_hi     = {1'b0, LOAD_BASE} + {1'b0, LOAD_SIZE};
  assign w_addr_ok    = ({1'b0, load_address} >= {1'b0, LOAD_BASE}) &&
                        ({1'b0, load_address} <  w_lim_hi);
  assign w_unused_cfg = ^cpu_addr[1:0];
`else
  logic               w_unused_cfg;
  assign w_addr_ok    = 1'b1;
  assign w_unused_cfg = ^{cpu_addr[1:0], LOAD_BASE, LOAD_SIZE};
`endif

  // --------------------------------------------------------------------------
  // FIFO status. The in-flight loader entry stays in the FIFO until its
  // memory transfer completes, so it still counts towards fullness.
  // --------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                   (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
  assign w_head  = r_fifo[r_rd_ptr[c_ptr_w-1:0]];

  assign w_xfer     = r_mem_valid & mem_ready;
  assign w_pop      = w_xfer & r_owner_ld;
  // load_error beats a simultaneous load_write: the byte is never queued.
  assign w_push_req = load_write & (r_state != S_ERROR) & ~load_error & w_addr_ok;
  assign w_overflow = w_push_req & w_full & ~w_pop;
  assign w_push     = w_push_req & ~w_overflow;
  assign w_addr_err = load_write & ~w_addr_ok & (r_state != S_ERROR);

  // The counter value is the number of consecutive idle cycles including
  // the current one, saturating at IDLE_TIMEOUT.
  assign w_idle_now     = ~load_write & w_empty;
  assign w_idle_cnt_nxt = !w_idle_now ? '0 :
                          (r_idle_cnt == c_idle_max) ? r_idle_cnt :
                          r_idle_cnt + 1'b1;

  // --------------------------------------------------------------------------
  // Next-state and grant logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_cpu_gnt    = 1'b0;
    w_ld_issue   = 1'b0;

    case (r_state)
      S_RUN: begin
        if (load_write) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_idle_now && (w_idle_cnt_nxt == c_idle_max) && !r_mem_valid) begin
          w_next_state = S_RUN;
        end
      end
      S_ERROR: begin
        w_next_state = S_ERROR;
      end
      default: begin
        w_next_state = S_ERROR;
      end
    endcase

    if ((r_state != S_ERROR) && (load_error || w_overflow || w_addr_err)) begin
      w_next_state = S_ERROR;
    end

    // r_cpu_reset_n keeps the grant off while the CPU is still held in reset.
    w_cpu_gnt = (r_state == S_RUN) & r_cpu_reset_n & cpu_req & w_empty &
                ~r_mem_valid & ~load_write & ~load_error;

    w_ld_issue = (r_state == S_LOAD) & (w_next_state != S_ERROR) &
                 ~r_mem_valid & ~w_empty;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_RUN;
      r_cpu_reset_n <= 1'b0;
      r_loading     <= 1'b0;
      r_error       <= 1'b0;
      r_idle_cnt    <= '0;
    end else begin
      r_state       <= w_next_state;
      r_cpu_reset_n <= (w_next_state == S_RUN);
      r_loading     <= (w_next_state == S_LOAD);
      r_error       <= (w_next_state == S_ERROR);
      r_idle_cnt    <= (r_state == S_LOAD) ? w_idle_cnt_nxt : '0;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers: flushed on (and while in) the error state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_next_state == S_ERROR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[c_ptr_w-1:0]] <= {load_address, load_byte};
    end
  end

  // --------------------------------------------------------------------------
  // Memory port. A new write is launched only when the port is empty, so
  // payload and owner cannot change while mem_valid waits for mem_ready.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_owner_ld  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_mem_valid <= 1'b0;
      end
      if (w_cpu_gnt) begin
        r_mem_valid <= 1'b1;
        r_mem_addr  <= {cpu_addr[31:2], 2'b00};
        r_mem_wdata <= cpu_wdata;
        r_mem_be    <= cpu_be;
        r_owner_ld  <= 1'b0;
      end else if (w_ld_issue) begin
        r_mem_valid <= 1'b1;
        r_mem_addr  <= {w_head[39:10], 2'b00};
        r_mem_wdata <= {4{w_head[7:0]}};
        r_mem_be    <= 4'b0001 << w_head[9:8];
        r_owner_ld  <= 1'b1;
      end
    end
  end

  assign cpu_gnt     = w_cpu_gnt;
  assign cpu_reset_n = r_cpu_reset_n;
  assign mem_valid   = r_mem_valid;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_be      = r_mem_be;
  assign loading     = r_loading;
  assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_srec_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_srec_load_arbiter
// Purpose  : Self-checking bench for srec_load_arbiter. A transaction-level
//            model keeps the ordered list of writes owed to memory, the load
//            state and the idle count, and every cycle the DUT outputs are
//            compared against it. Directed scenarios are followed by random
//            traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srec_load_arbiter;

  localparam int          DEPTH = 4;
  localparam int          TMO   = 8;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] SIZE  = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_error = 1'b0;
  logic [31:0] load_address = '0;
  logic [7:0]  load_byte = '0;
  logic        load_write = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_be = '0;
  logic        cpu_gnt;
  logic        cpu_reset_n;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic        loading;
  logic        error;

  always #5 clock = ~clock;

  srec_load_arbiter #(
    .FIFO_DEPTH  (DEPTH),
    .IDLE_TIMEOUT(TMO),
    .LOAD_BASE   (BASE),
    .LOAD_SIZE   (SIZE)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_error  (load_error),
    .load_address(load_address),
    .load_byte   (load_byte),
    .load_write  (load_write),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_be      (cpu_be),
    .cpu_gnt     (cpu_gnt),
    .cpu_reset_n (cpu_reset_n),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ready   (mem_ready),
    .loading     (loading),
    .error       (error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          from_cpu;
  } wr_t;

  typedef enum {M_RUN, M_LOAD, M_ERR} mstate_t;

  int      checks = 0;
  int      errors = 0;
  mstate_t m_state = M_RUN;
  bit      m_first = 1'b1;
  int      m_idle = 0;
  wr_t     q[$];
  bit      m_allow = 1'b0;
  wr_t     m_allow_item;
  bit      p_valid = 1'b0;
  bit      p_ready = 1'b0;
  bit      p_gnt = 1'b0;
  logic [95:0] p_port = '0;
  int      stall = 0;
  bit      cpu_want = 1'b0;
  logic [31:0] cpu_na, cpu_nd;
  logic [3:0]  cpu_nb;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
`ifdef SREC_LOAD_ADDR_LIMIT_EN
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + {1'b0, SIZE}));
`else
    return (a === a);
`endif
  endfunction

  function automatic wr_t loader_item(input logic [31:0] a, input logic [7:0] b);
    wr_t w;
    w.addr     = {a[31:2], 2'b00};
    w.data     = {b, b, b, b};
    w.be       = 4'(1 << a[1:0]);
    w.from_cpu = 1'b0;
    return w;
  endfunction

  function automatic logic [95:0] pack(input wr_t w);
    return {28'b0, w.be, w.addr, w.data};
  endfunction

  task automatic check_reset_outputs();
    check("rst_cpu_reset_n", cpu_reset_n, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_loading", loading, 0);
    check("rst_error", error, 0);
  endtask

  task automatic model_reset();
    m_state = M_RUN; m_first = 1'b1; m_idle = 0; q.delete(); m_allow = 1'b0;
    p_valid = 1'b0; p_ready = 1'b0; p_gnt = 1'b0; stall = 0;
    cpu_req = 1'b0; cpu_want = 1'b0;
  endtask

  // Asserts reset_n between edges and checks the asynchronous clear.
  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0; load_write = 1'b0; load_error = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
  endtask

  task automatic observe_and_model();
    bit xfer, exp_run, exp_gnt, bad, ovf, head_ld;
    int ldcnt;
    wr_t w, c;
    xfer    = mem_valid && mem_ready;
    exp_run = (m_state == M_RUN) && !m_first;
    check("cpu_reset_n", cpu_reset_n, exp_run);
    check("loading", loading, m_state == M_LOAD);
    check("error", error, m_state == M_ERR);
    exp_gnt = exp_run && cpu_req && (q.size() == 0) && !load_write && !load_error;
    check("cpu_gnt", cpu_gnt, exp_gnt);
    check("mem_addr_lsb", mem_addr[1:0], 0);
    if (q.size() == 0 && !m_allow) check("mem_valid_idle", mem_valid, 0);
    if (p_valid && !p_ready) begin
      check("hold_valid", mem_valid, 1);
      check("hold_payload", {28'b0, mem_be, mem_addr, mem_wdata}, p_port);
    end
    if (xfer) begin
      stall = 0;
      if (m_state == M_ERR) begin
        check("err_xfer_allowed", m_allow, 1);
        if (m_allow) check("err_xfer_payload", {28'b0, mem_be, mem_addr, mem_wdata}, pack(m_allow_item));
      end else begin
        check("xfer_unexpected", q.size() == 0, 0);
        if (q.size() != 0) check("xfer_payload", {28'b0, mem_be, mem_addr, mem_wdata}, pack(q[0]));
      end
    end else if (mem_ready && q.size() != 0 && m_state != M_ERR) begin
      stall++;
      if (stall > 4) begin
        check("issue_timeout", stall, 4);
        stall = 0;
      end
    end

    ldcnt = 0;
    foreach (q[i]) if (!q[i].from_cpu) ldcnt++;
    head_ld = (q.size() != 0) && !q[0].from_cpu;
    if (m_state == M_ERR) begin
      if (xfer) m_allow = 1'b0;
    end else begin
      bad = load_write && !in_window(load_address);
      ovf = load_write && !load_error && !bad && (ldcnt == DEPTH) && !(xfer && head_ld);
      if (load_error || ovf || bad) begin
        m_allow = (q.size() != 0) && !xfer;
        if (q.size() != 0) m_allow_item = q[0];
        q.delete();
        m_state = M_ERR;
      end else begin
        if (xfer && q.size() != 0) void'(q.pop_front());
        if (load_write) begin
          w = loader_item(load_address, load_byte);
          q.push_back(w);
        end
        if (exp_gnt) begin
          c.addr = {cpu_addr[31:2], 2'b00}; c.data = cpu_wdata; c.be = cpu_be; c.from_cpu = 1'b1;
          q.push_back(c);
        end
        if (m_state == M_RUN) begin
          if (load_write) begin m_state = M_LOAD; m_idle = 0; end
        end else begin
          if (load_write || ldcnt > 0) m_idle = 0; else m_idle++;
          if (m_idle == TMO) m_state = M_RUN;
        end
      end
    end
    m_first = 1'b0;
    p_valid = mem_valid; p_ready = mem_ready; p_gnt = cpu_gnt;
    p_port  = {28'b0, mem_be, mem_addr, mem_wdata};
  endtask

  task automatic cycle(input bit lw, input logic [31:0] la, input logic [7:0] lb,
                       input bit le, input bit mr);
    @(posedge clock); #1;
    reset_n = 1'b1;
    if (p_gnt) cpu_req = 1'b0;
    if (!cpu_req && cpu_want) begin
      cpu_req = 1'b1; cpu_addr = cpu_na; cpu_wdata = cpu_nd; cpu_be = cpu_nb; cpu_want = 1'b0;
    end
    load_write = lw; load_address = la; load_byte = lb; load_error = le; mem_ready = mr;
    @(negedge clock);
    observe_and_model();
  endtask

  task automatic idle(input int n, input bit mr);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 8'h0, 1'b0, mr);
  endtask

  task automatic cpu_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    cpu_want = 1'b1; cpu_na = a; cpu_nd = d; cpu_nb = b;
  endtask

  initial begin
    // Reset values while reset_n is held low.
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs();
    model_reset();

    // CPU write after reset release.
    idle(1, 1'b1);
    cpu_issue(32'h100, 32'hDEADBEEF, 4'hF);
    idle(5, 1'b1);

    // Three-byte load, then idle timeout back to RUN.
    cycle(1'b1, 32'h1001, 8'h11, 1'b0, 1'b1);
    cycle(1'b1, 32'h1002, 8'h22, 1'b0, 1'b1);
    cycle(1'b1, 32'h1003, 8'h33, 1'b0, 1'b1);
    idle(TMO + 12, 1'b1);

    // Backpressure overflow: fifth byte dropped, sticky error.
    do_reset();
    idle(1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h1000 + 32'(i), 8'(8'hA0 + i), 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(TMO + 6, 1'b1);
    check("ovf_error_sticky", error, 1);

    // Load arrives while a CPU write is stalled.
    do_reset();
    idle(1, 1'b1);
    cpu_issue(32'h200, 32'hCAFEF00D, 4'h3);
    idle(2, 1'b0);
    cpu_issue(32'h204, 32'h12345678, 4'hC);
    cycle(1'b1, 32'h1010, 8'h5A, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(TMO + 12, 1'b1);

    // load_error mid-load with two bytes queued.
    do_reset();
    idle(1, 1'b1);
    cycle(1'b1, 32'h1020, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 32'h1021, 8'h02, 1'b0, 1'b0);
    idle(1, 1'b0);
    cycle(1'b1, 32'h1022, 8'h03, 1'b1, 1'b0);
    idle(8, 1'b1);
    check("err_loading_low", loading, 0);

    // Load window edges.
    do_reset();
    idle(1, 1'b1);
    cycle(1'b1, 32'h10FF, 8'hEE, 1'b0, 1'b1);
    idle(3, 1'b1);
    cycle(1'b1, 32'h1100, 8'hDD, 1'b0, 1'b1);
    idle(TMO + 8, 1'b1);

    // Reset asserted while a CPU write is stalled.
    do_reset();
    idle(1, 1'b1);
    cpu_issue(32'h300, 32'h0BADF00D, 4'h1);
    idle(3, 1'b0);
    do_reset();
    idle(2, 1'b1);

    // Random traffic: bursts of loads separated by quiet gaps.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int t = 0; t < 300; t++) begin
        bit burst, lw, le, mr;
        logic [31:0] la;
        burst = ((t / 40) % 2) == 0;
        lw = burst && ($urandom_range(0, 3) == 0);
        le = ($urandom_range(0, 299) == 0);
        mr = ($urandom_range(0, 3) != 0);
        la = ($urandom_range(0, 63) == 0) ? (32'h2000 + 32'($urandom_range(0, 255)))
                                           : (BASE + 32'($urandom_range(0, 255)));
        if (!cpu_req && !cpu_want && $urandom_range(0, 7) == 0)
          cpu_issue($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom));
        cycle(lw, la, 8'($urandom), le, mr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
